// File: rtl/tns_decoder_12.sv
// tns_decoder_12: 12-bit TNS codeword to BLEN04-bit data decoder.
// Two-stage valid/ready pipeline with backpressure and range checking.
// Ports: clock, rst_n (async active-low), in_valid/in_ready/codein,
//   out_valid/out_ready/dataout/code_err, err_cnt (TNS_DEC_ERRCNT_EN).
// Optional: define TNS_DEC_ERRCNT_EN for a saturating code_err counter.
// Weights are taken from TNS.vh when it is included beforehand; the
//   fallback values below match the paired 12-bit encoder.

`ifndef BLEN04
`define BLEN04 8
`endif
`ifndef TNS01_A
`define TNS01_A 2
`endif
`ifndef TNS01_B
`define TNS01_B 1
`endif
`ifndef TNS02_A
`define TNS02_A 8
`endif
`ifndef TNS02_B
`define TNS02_B 5
`endif
`ifndef TNS02_C
`define TNS02_C 3
`endif
`ifndef TNS03_A
`define TNS03_A 34
`endif
`ifndef TNS03_B
`define TNS03_B 21
`endif
`ifndef TNS03_C
`define TNS03_C 13
`endif
`ifndef TNS04_A
`define TNS04_A 144
`endif
`ifndef TNS04_B
`define TNS04_B 89
`endif
`ifndef TNS04_C
`define TNS04_C 55
`endif

module tns_decoder_12 #(
  parameter int DW   = `BLEN04,
  parameter int SUMW = `BLEN04 + 1
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [11:0]   codein,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dataout,
  output logic          code_err
`ifdef TNS_DEC_ERRCNT_EN
  ,
  output logic [15:0]   err_cnt
`endif
);

  localparam logic [SUMW-1:0] W11 = SUMW'(`TNS04_A);
  localparam logic [SUMW-1:0] W10 = SUMW'(`TNS04_B);
  localparam logic [SUMW-1:0] W9  = SUMW'(`TNS04_C);
  localparam logic [SUMW-1:0] W8  = SUMW'(`TNS03_A);
  localparam logic [SUMW-1:0] W7  = SUMW'(`TNS03_B);
  localparam logic [SUMW-1:0] W6  = SUMW'(`TNS03_C);
  localparam logic [SUMW-1:0] W5  = SUMW'(`TNS02_A);
  localparam logic [SUMW-1:0] W4  = SUMW'(`TNS02_B);
  localparam logic [SUMW-1:0] W3  = SUMW'(`TNS02_C);
  localparam logic [SUMW-1:0] W2  = SUMW'(`TNS01_A);
  localparam logic [SUMW-1:0] W1  = SUMW'(`TNS01_B);
  localparam logic [SUMW-1:0] W0  = SUMW'(1);

  // Largest value representable in DW bits.
  localparam logic [SUMW-1:0] MAXV = SUMW'((1 << DW) - 1);

  logic            w_adv;
  logic            r_s1_valid;
  logic [SUMW-1:0] r_g4;
  logic [SUMW-1:0] r_g3;
  logic [SUMW-1:0] r_g2;
  logic [SUMW-1:0] r_g1;
  logic [SUMW-1:0] w_g4;
  logic [SUMW-1:0] w_g3;
  logic [SUMW-1:0] w_g2;
  logic [SUMW-1:0] w_g1;
  logic [SUMW-1:0] w_sum;

  // Whole pipe moves together; in_ready never looks at in_valid.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  assign w_g4 = (codein[11] ? W11 : '0)
              + (codein[10] ? W10 : '0)
              + (codein[9]  ? W9  : '0);
  assign w_g3 = (codein[8]  ? W8  : '0)
              + (codein[7]  ? W7  : '0)
              + (codein[6]  ? W6  : '0);
  assign w_g2 = (codein[5]  ? W5  : '0)
              + (codein[4]  ? W4  : '0)
              + (codein[3]  ? W3  : '0);
  assign w_g1 = (codein[2]  ? W2  : '0)
              + (codein[1]  ? W1  : '0)
              + (codein[0]  ? W0  : '0);

  assign w_sum = r_g4 + r_g3 + r_g2 + r_g1;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_g4       <= '0;
      r_g3       <= '0;
      r_g2       <= '0;
      r_g1       <= '0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_g4 <= w_g4;
        r_g3 <= w_g3;
        r_g2 <= w_g2;
        r_g1 <= w_g1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dataout   <= '0;
      code_err  <= 1'b0;
    end else if (w_adv) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        dataout  <= w_sum[DW-1:0];
        code_err <= (w_sum > MAXV);
      end
    end
  end

`ifdef TNS_DEC_ERRCNT_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && code_err
                 && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
